preload_fifo_ctrl: RTL and testbench



---
 rtl/preload_pkg.sv | 31 +++
 rtl/preload_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_preload_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/preload_pkg.sv
// ============================================================================
// Module   : preload_pkg
// Purpose  : Shared state encoding and packing constants for the preload FIFO
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package preload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int CH_PER_WORD = 6;
    localparam int WPR_W       = 10;
    localparam int CH_SIZE_W   = 12;

    // Beats per FIFO entry; the +1 always reserves a beat even for exact multiples.
    function automatic logic [WPR_W-1:0] calc_wpr(input logic [CH_SIZE_W-1:0] ch);
        logic [CH_SIZE_W-1:0] quot;
        quot = ch / CH_SIZE_W'(CH_PER_WORD);
        return quot[WPR_W-1:0] + WPR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/preload_fifo_ctrl.sv
// ============================================================================
// Module   : preload_fifo_ctrl
// Purpose  : Loads an AXIS ifmap burst into the preload FIFO and pops only
//            fully packed entries to the MAC array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module preload_fifo_ctrl
    import preload_pkg::*;
#(
    parameter int AXIS_PRELOAD_FIFO_DEPTH = 4,
    parameter int ROW_CNT_W               = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CH_SIZE_W-1:0] input_channel_size_i,
    input  logic [ROW_CNT_W-1:0] row_count_i,
    input  logic                 s_axis_tvalid_i,
    input  logic                 s_axis_tlast_i,
    output logic                 s_axis_tready_o,
    output logic                 load_axis_preload_o,
    input  logic                 fifo_full_i,
    input  logic                 fifo_empty_i,
    input  logic                 mac_ready_i,
    output logic                 fifo_read_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_tlast_o
);

    generate
        if (AXIS_PRELOAD_FIFO_DEPTH < 1) begin : g_depth_check
            $error("AXIS_PRELOAD_FIFO_DEPTH must be at least 1");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [WPR_W-1:0]     wpr_q;
    logic [WPR_W-1:0]     word_cnt_q;
    logic [ROW_CNT_W-1:0] rows_total_q;
    logic [ROW_CNT_W-1:0] rows_wr_q;
    logic [ROW_CNT_W-1:0] rows_rd_q;
    logic                 err_q;

    logic                 start_acc;
    logic                 row_end;
    logic                 final_beat;
    logic                 beat_acc;
    logic [ROW_CNT_W-1:0] avail;
    logic [ROW_CNT_W-1:0] rows_rd_next;

    assign start_acc    = start_i & (state_q == ST_IDLE);
    assign row_end      = (word_cnt_q == wpr_q - WPR_W'(1));
    assign final_beat   = row_end & (rows_wr_q == rows_total_q - ROW_CNT_W'(1));
    assign beat_acc     = s_axis_tvalid_i & s_axis_tready_o;
    // Only complete entries count; a partially written entry already clears fifo_empty.
    assign avail        = rows_wr_q - rows_rd_q;
    assign rows_rd_next = rows_rd_q + ROW_CNT_W'(fifo_read_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = (row_count_i == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (beat_acc && final_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (rows_rd_next == rows_total_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_read_o         = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) &&
                              mac_ready_i && !fifo_empty_i && (avail != '0);
        s_axis_tready_o     = (state_q == ST_LOAD) && (!fifo_full_i || fifo_read_o);
        load_axis_preload_o = s_axis_tvalid_i & s_axis_tready_o;
        busy_o              = (state_q != ST_IDLE);
        done_o              = (state_q == ST_DONE);
        err_tlast_o         = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wpr_q        <= '0;
            word_cnt_q   <= '0;
            rows_total_q <= '0;
            rows_wr_q    <= '0;
            rows_rd_q    <= '0;
            err_q        <= 1'b0;
        end else if (start_acc) begin
            wpr_q        <= calc_wpr(input_channel_size_i);
            word_cnt_q   <= '0;
            rows_total_q <= row_count_i;
            rows_wr_q    <= '0;
            rows_rd_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            if (beat_acc) begin
                // tlast only flags framing; the transfer length is set by the counters.
                if (s_axis_tlast_i != final_beat) err_q <= 1'b1;
                if (row_end) begin
                    word_cnt_q <= '0;
                    rows_wr_q  <= rows_wr_q + ROW_CNT_W'(1);
                end else begin
                    word_cnt_q <= word_cnt_q + WPR_W'(1);
                end
            end
            if (fifo_read_o) rows_rd_q <= rows_rd_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_preload_fifo_ctrl.sv
// ============================================================================
// Module   : tb_preload_fifo_ctrl
// Purpose  : Self-checking bench for preload_fifo_ctrl with a FIFO model and a
//            count-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_preload_fifo_ctrl;
    import preload_pkg::*;

    localparam int DEPTH = 4;
    localparam int RW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [11:0]   ch = '0;
    logic [RW-1:0] rows = '0;
    logic          tvalid = 1'b0, tlast = 1'b0, mac_ready = 1'b0;
    logic          fifo_full = 1'b0, fifo_empty = 1'b1;
    logic          tready, load, fifo_read, busy, done, err;

    always #5 clk = ~clk;

    preload_fifo_ctrl #(.AXIS_PRELOAD_FIFO_DEPTH(DEPTH), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .input_channel_size_i(ch), .row_count_i(rows),
        .s_axis_tvalid_i(tvalid), .s_axis_tlast_i(tlast),
        .s_axis_tready_o(tready), .load_axis_preload_o(load),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .mac_ready_i(mac_ready), .fifo_read_o(fifo_read),
        .busy_o(busy), .done_o(done), .err_tlast_o(err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: tile progress as plain counts.
    bit m_tile, m_done_now, m_err;
    int m_rows, m_wpr, m_beats, m_pops;
    bit e_tready, e_read, e_load;
    bit a_load, a_read;

    // FIFO model: complete entries by id plus beats of the entry being packed.
    int fq[$];
    int pop_ids[$];
    int f_partial, f_next_id;

    typedef struct {
        bit start, tvalid, tlast, mac;
        bit e_tready, e_read, e_done, e_busy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void update_flags();
        fifo_full  = (fq.size() == DEPTH);
        fifo_empty = (fq.size() == 0) && (f_partial == 0);
    endfunction

    // Compare at the falling edge against the model for the current cycle.
    task automatic sample();
        int total, avail;
        @(negedge clk);
        total    = m_rows * m_wpr;
        avail    = (m_wpr == 0) ? 0 : (m_beats / m_wpr - m_pops);
        e_read   = m_tile && mac_ready && !fifo_empty && (avail > 0);
        e_tready = m_tile && (m_beats < total) && (!fifo_full || e_read);
        e_load   = tvalid && e_tready;
        chk("tready", tready, e_tready);
        chk("fifo_read", fifo_read, e_read);
        chk("load", load, e_load);
        chk("busy", busy, m_tile || m_done_now);
        chk("done", done, m_done_now);
        chk("err_tlast", err, m_err);
        a_load = load;
        a_read = fifo_read;
    endtask

    task automatic advance();
        bit done_next;
        int total;
        done_next = 0;
        total     = m_rows * m_wpr;
        if (start && !m_tile && !m_done_now) begin
            m_rows = rows; m_wpr = ch / 6 + 1;
            m_beats = 0; m_pops = 0; m_err = 0;
            f_partial = 0; f_next_id = 0; fq.delete(); pop_ids.delete();
            if (rows == 0) done_next = 1; else m_tile = 1;
        end else begin
            if (e_load) begin
                if (tlast != (m_beats == total - 1)) m_err = 1;
                m_beats++;
            end
            if (e_read) begin
                m_pops++;
                if (m_pops == m_rows) begin m_tile = 0; done_next = 1; end
            end
        end
        m_done_now = done_next;
        @(posedge clk);
        #1;
        if (a_read && fq.size() > 0) pop_ids.push_back(fq.pop_front());
        if (a_load) begin
            f_partial++;
            if (f_partial >= m_wpr) begin fq.push_back(f_next_id); f_next_id++; f_partial = 0; end
        end
        update_flags();
    endtask

    task automatic hard_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tready", tready, 0); chk("rst_load", load, 0);
        chk("rst_fifo_read", fifo_read, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_err", err, 0);
        start = 0; tvalid = 0; tlast = 0; mac_ready = 0;
        m_tile = 0; m_done_now = 0; m_err = 0; m_rows = 0; m_wpr = 0; m_beats = 0; m_pops = 0;
        fq.delete(); pop_ids.delete(); f_partial = 0; f_next_id = 0;
        update_flags();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic begin_tile(input int c, input int r);
        ch = 12'(c); rows = RW'(r); start = 1; tvalid = 0; tlast = 0;
        sample(); advance();
        start = 0;
    endtask

    task automatic drive_until_done(input int vpct, input int mpct, input int bad_pct, input int bad_beat);
        bit seen, fin;
        seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            tvalid    = ($urandom_range(99) < vpct);
            mac_ready = ($urandom_range(99) < mpct);
            fin       = (m_beats == m_rows * m_wpr - 1);
            tlast     = fin;
            if (m_beats == bad_beat) tlast = !fin;
            if ($urandom_range(99) < bad_pct) tlast = !tlast;
            sample();
            seen = done;
            advance();
        end
        tvalid = 0; tlast = 0;
        chk("done_within_budget", seen, 1);
    endtask

    initial begin
        update_flags();
        hard_reset();

        // C=12, rows=2: cycle-exact table from start.
        tbl[0] = '{1,0,0,1, 0,0,0,0};
        tbl[1] = '{0,1,0,1, 1,0,0,1};
        tbl[2] = '{0,1,0,1, 1,0,0,1};
        tbl[3] = '{0,1,0,1, 1,0,0,1};
        tbl[4] = '{0,1,0,1, 1,1,0,1};
        tbl[5] = '{0,1,0,1, 1,0,0,1};
        tbl[6] = '{0,1,1,1, 1,0,0,1};
        tbl[7] = '{0,0,0,1, 0,1,0,1};
        tbl[8] = '{0,0,0,1, 0,0,1,1};
        tbl[9] = '{0,0,0,1, 0,0,0,0};
        ch = 12; rows = 2;
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; tvalid = tbl[i].tvalid;
            tlast = tbl[i].tlast; mac_ready = tbl[i].mac;
            sample();
            chk($sformatf("tbl%0d_tready", i), tready, tbl[i].e_tready);
            chk($sformatf("tbl%0d_read", i), fifo_read, tbl[i].e_read);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            advance();
        end
        chk("tbl_err_clear", err, 0);

        // C=5, rows=6: stall at full, then simultaneous pop and accept.
        begin_tile(5, 6);
        mac_ready = 0; tvalid = 1; tlast = 0;
        for (int i = 0; i < 6; i++) begin sample(); advance(); end
        sample();
        chk("full_flag", fifo_full, 1);
        chk("full_stall_tready", tready, 0);
        advance();
        mac_ready = 1;
        sample();
        chk("same_cycle_pop", fifo_read, 1);
        chk("same_cycle_accept", load, 1);
        advance();
        drive_until_done(100, 100, 0, -1);
        chk("pop_count", pop_ids.size(), 6);
        for (int i = 0; i < pop_ids.size(); i++) chk($sformatf("pop_order%0d", i), pop_ids[i], i);

        // C=30, rows=1: six beats per entry, no pop of the partial entry.
        begin_tile(30, 1);
        tvalid = 1; mac_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tlast = (i == 5);
            sample();
            chk($sformatf("partial_no_pop%0d", i), fifo_read, 0);
            advance();
        end
        tvalid = 0; tlast = 0;
        sample();
        chk("partial_pop_after_beat5", fifo_read, 1);
        advance();
        drive_until_done(100, 100, 0, -1);

        // rows=0: done on the next cycle with no beats accepted.
        begin_tile(12, 0);
        tvalid = 1;
        sample();
        chk("rows0_done", done, 1);
        chk("rows0_tready", tready, 0);
        advance();
        sample();
        chk("rows0_done_once", done, 0);
        advance();
        tvalid = 0;

        // Early tlast on beat 2 of 6; the second start clears the flag.
        begin_tile(12, 2);
        drive_until_done(100, 100, 0, 2);
        sample();
        chk("err_sticky", err, 1);
        advance();
        begin_tile(12, 2);
        sample();
        chk("err_cleared_by_start", err, 0);
        advance();
        drive_until_done(80, 80, 0, -1);

        // Reset during LOAD, then a fresh tile.
        begin_tile(12, 3);
        tvalid = 1; mac_ready = 1;
        for (int i = 0; i < 4; i++) begin sample(); advance(); end
        hard_reset();
        begin_tile(12, 3);
        drive_until_done(100, 100, 0, -1);
        chk("post_reset_pops", pop_ids.size(), 3);

        // Randomized tiles.
        for (int t = 0; t < 25; t++) begin
            begin_tile($urandom_range(40), $urandom_range(6));
            drive_until_done($urandom_range(100, 40), $urandom_range(100, 20),
                             (t % 3 == 0) ? 10 : 0, -1);
            for (int k = 0; k < 2; k++) begin sample(); advance(); end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
